// File: rtl/aes_enc_iter.sv
// Iterative AES-128 encryptor: one round per clock with the key schedule expanded on the fly.
// Define AES_ENC_KEYOUT_EN to add the key_out port carrying the captured round-10 key.
module aes_enc_iter #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] plaintext,
    input  logic [127:0] key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] cipher_text,
`ifdef AES_ENC_KEYOUT_EN
    output logic [127:0] key_out,
`endif
    output logic [1:0]   dbg_state
);

    // Handshake: a transfer happens on a rising clk edge where valid && ready are both
    // high; the producer holds valid and its data stable until that edge.

    generate
        if (NR != 10) begin : g_nr_check
            $error("aes_enc_iter: only NR = 10 (AES-128) is supported");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] NR_L = 4'(NR);

    // Forward S-box, byte 0x00 in the most significant position.
    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] rnd);
        case (rnd)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; byte index = 4*column + row.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(4*c + r) -: 8] = sbox(s[127 - 8*(4*((c + r) % 4) + r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127 - 32*c -: 8];
            a1 = s[119 - 32*c -: 8];
            a2 = s[111 - 32*c -: 8];
            a3 = s[103 - 32*c -: 8];
            o[127 - 32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119 - 32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111 - 32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103 - 32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3, t, n0, n1, n2, n3;
        w3 = k[31:0];
        t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
        n0 = k[127:96] ^ t;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = w3 ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    state_t       st_q, st_d;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [3:0]   rnd_q, rnd_d;
    logic [127:0] ct_q, ct_d;
    logic         out_valid_q, out_valid_d;
    logic         in_ready_q, in_ready_d;
`ifdef AES_ENC_KEYOUT_EN
    logic [127:0] key_out_q, key_out_d;
`endif

    logic [127:0] rkey_next, sr_out, round_out;

    assign rkey_next = key_expand(rkey_q, rcon(rnd_q));
    assign sr_out    = sub_shift(state_q);
    assign round_out = ((rnd_q == NR_L) ? sr_out : mix_columns(sr_out)) ^ rkey_next;

    always_comb begin
        st_d        = st_q;
        state_d     = state_q;
        rkey_d      = rkey_q;
        rnd_d       = rnd_q;
        ct_d        = ct_q;
        out_valid_d = out_valid_q;
`ifdef AES_ENC_KEYOUT_EN
        key_out_d   = key_out_q;
`endif
        case (st_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    state_d = plaintext ^ key;
                    rkey_d  = key;
                    rnd_d   = 4'd1;
                    st_d    = RUN;
                end
            end
            RUN: begin
                state_d = round_out;
                rkey_d  = rkey_next;
                rnd_d   = rnd_q + 4'd1;
                if (rnd_q == NR_L) begin
                    // Counter parks at zero so it never passes NR.
                    rnd_d       = 4'd0;
                    ct_d        = round_out;
                    out_valid_d = 1'b1;
`ifdef AES_ENC_KEYOUT_EN
                    key_out_d   = rkey_next;
`endif
                    st_d        = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    st_d        = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
        // Registered so in_ready stays low through reset and rises one edge after release.
        in_ready_d = (st_d == IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q        <= IDLE;
            state_q     <= '0;
            rkey_q      <= '0;
            rnd_q       <= '0;
            ct_q        <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b0;
`ifdef AES_ENC_KEYOUT_EN
            key_out_q   <= '0;
`endif
        end else begin
            st_q        <= st_d;
            state_q     <= state_d;
            rkey_q      <= rkey_d;
            rnd_q       <= rnd_d;
            ct_q        <= ct_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
`ifdef AES_ENC_KEYOUT_EN
            key_out_q   <= key_out_d;
`endif
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign cipher_text = ct_q;
`ifdef AES_ENC_KEYOUT_EN
    assign key_out     = key_out_q;
`endif
    assign dbg_state   = st_q;

endmodule

// File: tb/tb_aes_enc_iter.sv
// Self-checking bench for aes_enc_iter: FIPS-197 vectors, stalls, reset abort and a random stream
// against an independent software AES-128 model.
module tb_aes_enc_iter;

    localparam logic [127:0] V1_PT = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] V1_K  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] V1_CT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] V1_KO = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] V2_PT = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] V2_K  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] V2_CT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] V2_KO = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] plaintext, key, cipher_text;
`ifdef AES_ENC_KEYOUT_EN
    logic [127:0] key_out;
`endif
    logic [1:0]   dbg_state;

    aes_enc_iter #(.NR(10)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .plaintext  (plaintext),
        .key        (key),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .cipher_text(cipher_text),
`ifdef AES_ENC_KEYOUT_EN
        .key_out    (key_out),
`endif
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int           n_cmp = 0;
    int           n_err = 0;
    logic [127:0] exp_q[$];
    int           acc_cyc[$];
    logic [7:0]   sb_m[256];
    logic [127:0] dir_pt[2];
    logic [127:0] dir_k[2];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its algebraic definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        logic [7:0] inv, b, r;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            r = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
            sb_m[x] = r;
        end
    endtask

    task automatic aes_model(input logic [127:0] pt, input logic [127:0] k,
                             output logic [127:0] ct, output logic [127:0] last_key);
        logic [7:0] s[16], ns[16], rk[16], t[4], rc, a0, a1, a2, a3;
        rc = 8'h01;
        for (int i = 0; i < 16; i++) begin
            rk[i] = k[127 - 8*i -: 8];
            s[i]  = pt[127 - 8*i -: 8] ^ rk[i];
        end
        for (int r = 1; r <= 10; r++) begin
            t[0] = sb_m[rk[13]] ^ rc;
            t[1] = sb_m[rk[14]];
            t[2] = sb_m[rk[15]];
            t[3] = sb_m[rk[12]];
            for (int i = 0; i < 4; i++) rk[i] = rk[i] ^ t[i];
            for (int i = 4; i < 16; i++) rk[i] = rk[i] ^ rk[i-4];
            rc = gmul(rc, 8'h02);
            for (int c = 0; c < 4; c++)
                for (int w = 0; w < 4; w++)
                    ns[4*c + w] = sb_m[s[4*((c + w) % 4) + w]];
            for (int c = 0; c < 4; c++) begin
                a0 = ns[4*c]; a1 = ns[4*c+1]; a2 = ns[4*c+2]; a3 = ns[4*c+3];
                if (r < 10) begin
                    s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                    s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                    s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                    s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
                end else begin
                    s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
        end
        for (int i = 0; i < 16; i++) begin
            ct[127 - 8*i -: 8]       = s[i];
            last_key[127 - 8*i -: 8] = rk[i];
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic wait_ready(input string tag);
        int w;
        w = 0;
        in_valid = 1'b0;
        while (!in_ready && w < 30) begin
            tick();
            w++;
        end
        check({tag, "_in_ready"}, 128'(in_ready), 128'd1);
    endtask

    // One block: accept, bounded wait for out_valid, optional stall, then handoff.
    task automatic do_block(input string tag, input logic [127:0] pt, input logic [127:0] k,
                            input logic [127:0] exp_ct, input logic [127:0] exp_ko, input int hold);
        int lat;
        wait_ready(tag);
        plaintext = pt; key = k; in_valid = 1'b1;
        out_ready = (hold == 0);
        tick();
        in_valid = 1'b0;
        check({tag, "_state_run"}, 128'(dbg_state), 128'd1);
        lat = 0;
        while (!out_valid && lat < 30) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'd10);
        check({tag, "_ct"}, cipher_text, exp_ct);
`ifdef AES_ENC_KEYOUT_EN
        check({tag, "_key_out"}, key_out, exp_ko);
`else
        if (exp_ko === 128'hx) $display("note: no key_out expectation");
`endif
        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_flags"}, {126'd0, out_valid, in_ready}, 128'b10);
            check({tag, "_hold_ct"}, cipher_text, exp_ct);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check({tag, "_ov_drop"}, 128'(out_valid), 128'd0);
        check({tag, "_ready_back"}, 128'(in_ready), 128'd1);
        check({tag, "_ct_kept"}, cipher_text, exp_ct);
    endtask

    task automatic run_stream(input string tag, input int nblk, input bit rnd_mode);
        int           sent, got, budget;
        bit           pend;
        logic [127:0] m_ct, m_ko, e;
        sent = 0; got = 0; pend = 1'b0;
        budget = nblk * 40 + 100;
        in_valid = 1'b0;
        for (int c = 0; c < budget && got < nblk; c++) begin
            if (!pend && sent < nblk && (!rnd_mode || $urandom_range(0, 3) != 0)) begin
                pend = 1'b1;
                if (rnd_mode) begin
                    plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
                    key       = {$urandom(), $urandom(), $urandom(), $urandom()};
                end else begin
                    plaintext = dir_pt[sent];
                    key       = dir_k[sent];
                end
                in_valid = 1'b1;
            end
            out_ready = rnd_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (in_valid && in_ready) begin
                aes_model(plaintext, key, m_ct, m_ko);
                exp_q.push_back(m_ct);
                acc_cyc.push_back(cyc);
                sent++;
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                e = (exp_q.size() != 0) ? exp_q.pop_front() : 128'hx;
                check({tag, "_ct"}, cipher_text, e);
                got++;
            end
            tick();
            if (!pend) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        check({tag, "_count"}, 128'(got), 128'(nblk));
        check({tag, "_leftover"}, 128'(exp_q.size()), 128'd0);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] m_ct, m_ko;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        plaintext = '0; key = '0;
        dir_pt[0] = V1_PT; dir_k[0] = V1_K;
        dir_pt[1] = V2_PT; dir_k[1] = V2_K;
        build_sbox();

        // Reset values
        repeat (3) tick();
        check("rst_in_ready", 128'(in_ready), 128'd0);
        check("rst_out_valid", 128'(out_valid), 128'd0);
        check("rst_ct", cipher_text, 128'd0);
        check("rst_state", 128'(dbg_state), 128'd0);
`ifdef AES_ENC_KEYOUT_EN
        check("rst_key_out", key_out, 128'd0);
`endif
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", 128'(in_ready), 128'd0);
        tick();
        check("rel_in_ready_high", 128'(in_ready), 128'd1);

        // Model self-consistency against the published vector
        aes_model(V1_PT, V1_K, m_ct, m_ko);
        if (m_ct !== V1_CT || m_ko !== V1_KO) $display("note: software model disagrees with vector 1");

        // 1. FIPS-197 Appendix B vector
        do_block("t1", V1_PT, V1_K, V1_CT, V1_KO, 0);

        // 2. Appendix C.1 vector with a 20-cycle downstream stall
        do_block("t2", V2_PT, V2_K, V2_CT, V2_KO, 20);

        // 3. Back-to-back accepts
        acc_cyc.delete();
        run_stream("t3", 2, 1'b0);
        if (acc_cyc.size() == 2)
            check("t3_accept_gap", 128'(acc_cyc[1] - acc_cyc[0]), 128'd12);
        else
            check("t3_accept_count", 128'(acc_cyc.size()), 128'd2);

        // 4. Inputs scrambled while the block is in flight
        wait_ready("t4");
        plaintext = V1_PT; key = V1_K; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        for (int i = 0; i < 10; i++) begin
            plaintext = {$urandom(), $urandom(), $urandom(), $urandom()};
            key       = {$urandom(), $urandom(), $urandom(), $urandom()};
            in_valid  = 1'($urandom_range(0, 1));
            tick();
        end
        in_valid = 1'b0;
        check("t4_out_valid", 128'(out_valid), 128'd1);
        check("t4_ct", cipher_text, V1_CT);
        tick();
        check("t4_ov_drop", 128'(out_valid), 128'd0);

        // 5. Reset in the middle of a block
        wait_ready("t5");
        plaintext = V2_PT; key = V2_K; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        rst_n = 1'b0;
        #1;
        check("t5_out_valid", 128'(out_valid), 128'd0);
        check("t5_ct_cleared", cipher_text, 128'd0);
        check("t5_in_ready", 128'(in_ready), 128'd0);
        check("t5_state", 128'(dbg_state), 128'd0);
        repeat (2) tick();
        check("t5_no_pulse", 128'(out_valid), 128'd0);
        rst_n = 1'b1;
        tick();
        do_block("t5_rerun", V1_PT, V1_K, V1_CT, V1_KO, 0);

        // 6. Random stream with stalls on both sides
        run_stream("t6", 1000, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
